// File: rtl/key_schedule_inv_pkg.sv
// Shared types and constants for the AES-128 inverse key schedule.
package key_schedule_inv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  localparam int NR = 10;

  // rcon(0..10); byte for index i sits at bits [(10-i)*8 +: 8]. Index 0 is unused.
  localparam logic [87:0] RCON_TABLE = 88'h00_01_02_04_08_10_20_40_80_1b_36;

endpackage

// File: rtl/key_schedule_inv_word_ops.sv
// One round of the AES-128 key recurrence, forward (dir=0) or inverse (dir=1).
// The four S-boxes are shared: forward feeds w3, inverse feeds the recovered w3' = w3^w2.
module key_word_ops
  import key_schedule_inv_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic         dir,
  input  logic [7:0]   rcon_val,
  output logic [127:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sb_in, sb_out, t;
  logic [31:0] f0, f1, f2, f3;

  assign {w0, w1, w2, w3} = key_in;
  assign sb_in = dir ? (w3 ^ w2) : w3;

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    sbox u_sbox (
      .din  (sb_in[8*i +: 8]),
      .dout (sb_out[8*i +: 8])
    );
  end

  // SubWord then RotWord is the same as RotWord then SubWord; rotate the S-box outputs.
  assign t = {sb_out[23:0], sb_out[31:24]} ^ {rcon_val, 24'h0};

  assign f0 = w0 ^ t;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  assign key_out = dir ? {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2} : {f0, f1, f2, f3};

endmodule

// File: rtl/rcon.sv
// Round-constant lookup: rcon(1..10); any other index yields zero.
module rcon
  import key_schedule_inv_pkg::*;
(
  input  logic [3:0] idx,
  output logic [7:0] value
);

  // Table lookup with out-of-range indices forced to zero.
  always_comb begin
    value = 8'h00;
    if (idx >= 4'd1 && idx <= 4'(NR)) begin
      value = RCON_TABLE[(NR - int'(idx)) * 8 +: 8];
    end
  end

endmodule

// File: rtl/sbox.sv
// AES forward S-box as a constant table. Entry for input b sits at bits [(255-b)*8 +: 8].
module sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // (255 - din) * 8 is simply {~din, 3'b000}.
  assign dout = SBOX_TABLE[{~din, 3'b000} +: 8];

endmodule

// File: rtl/key_schedule_inv.sv
// AES-128 decryption-side key schedule: expands to K10, then walks back one round per next.
//
// state  | meaning
// IDLE   | no key loaded, outputs idle
// EXPAND | forward recurrence running, round counts 0 -> 10
// READY  | round_key = K(round); accepts next / rewind / load
module key_schedule_inv
  import key_schedule_inv_pkg::*;
#(
  parameter bit KEEP_LAST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] key,
  input  logic         next,
  input  logic         rewind,
  output logic [127:0] round_key,
  output logic [3:0]   round,
  output logic         valid,
  output logic         busy
);

  state_t       state, state_d;
  logic [127:0] key_d, step_out, k10_q;
  logic [3:0]   round_d, rcon_idx;
  logic [7:0]   rcon_val;
  logic         dir, k10_we;

  assign dir      = (state == READY);
  assign rcon_idx = dir ? round : round + 4'd1;

  rcon u_rcon (
    .idx   (rcon_idx),
    .value (rcon_val)
  );

  key_word_ops u_ops (
    .key_in   (round_key),
    .dir      (dir),
    .rcon_val (rcon_val),
    .key_out  (step_out)
  );

  // Next-state and datapath selection; READY priority is load > rewind > next.
  always_comb begin
    state_d = state;
    key_d   = round_key;
    round_d = round;
    k10_we  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          key_d   = key;
          round_d = 4'd0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        key_d   = step_out;
        round_d = round + 4'd1;
        if (round == 4'(NR - 1)) begin
          state_d = READY;
          k10_we  = 1'b1;
        end
      end
      READY: begin
        if (load) begin
          key_d   = key;
          round_d = 4'd0;
          state_d = EXPAND;
        end else if (rewind && KEEP_LAST) begin
          key_d   = k10_q;
          round_d = 4'(NR);
        end else if (next && round != 4'd0) begin
          key_d   = step_out;
          round_d = round - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, key and round registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      round_key <= '0;
      round     <= 4'd0;
    end else begin
      state     <= state_d;
      round_key <= key_d;
      round     <= round_d;
    end
  end

  if (KEEP_LAST) begin : g_keep_last
    // K10 copy captured on the last expansion step so rewind costs one cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        k10_q <= '0;
      end else if (k10_we) begin
        k10_q <= step_out;
      end
    end
  end else begin : g_no_keep_last
    assign k10_q = '0;
  end

  assign valid = (state == READY);
  assign busy  = (state == EXPAND);

endmodule

// File: tb/tb_key_schedule_inv.sv
// Bench for key_schedule_inv: round keys come from a forward FIPS-197 expansion model
// whose S-box is computed from GF(2^8) inversion plus the affine map.
module tb_key_schedule_inv;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst, load, next, rewind;
  logic [127:0] key;
  logic [127:0] rk1, rk0;
  logic [3:0]   round1, round0;
  logic         valid1, valid0, busy1, busy0;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] rk [0:10];

  always #5 clk = ~clk;

  key_schedule_inv #(.KEEP_LAST(1'b1)) dut (
    .clk(clk), .rst(rst), .load(load), .key(key), .next(next), .rewind(rewind),
    .round_key(rk1), .round(round1), .valid(valid1), .busy(busy1)
  );

  key_schedule_inv #(.KEEP_LAST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .key(key), .next(next), .rewind(rewind),
    .round_key(rk0), .round(round0), .valid(valid0), .busy(busy0)
  );

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic build_rk(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string tag, input int w, input int r, input logic v, input logic b);
    logic [127:0] k;
    logic [3:0]   rr;
    logic         vv, bb;
    if (w == 1) begin k = rk1; rr = round1; vv = valid1; bb = busy1; end
    else        begin k = rk0; rr = round0; vv = valid0; bb = busy0; end
    chk($sformatf("%s_d%0d_key", tag, w),   k,          rk[r]);
    chk($sformatf("%s_d%0d_round", tag, w), 128'(rr),   128'(r));
    chk($sformatf("%s_d%0d_valid", tag, w), 128'(vv),   128'(v));
    chk($sformatf("%s_d%0d_busy", tag, w),  128'(bb),   128'(b));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_d1_key"}, rk1, '0);
    chk({tag, "_d1_round"}, 128'(round1), '0);
    chk({tag, "_d1_vb"}, 128'({valid1, busy1}), '0);
    chk({tag, "_d0_key"}, rk0, '0);
    chk({tag, "_d0_round"}, 128'(round0), '0);
    chk({tag, "_d0_vb"}, 128'({valid0, busy0}), '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load sampled at the next edge, then the 10 expansion edges, checking every step.
  task automatic load_and_expand(input string tag, input logic [127:0] k);
    build_rk(k);
    key = k; load = 1'b1;
    tick();
    load = 1'b0;
    for (int w = 0; w < 2; w++) chk_dut({tag, "_k0"}, w, 0, 1'b0, 1'b1);
    for (int j = 1; j <= 9; j++) begin
      tick();
      for (int w = 0; w < 2; w++) chk_dut({tag, "_exp"}, w, j, 1'b0, 1'b1);
    end
    tick();
    for (int w = 0; w < 2; w++) chk_dut({tag, "_k10"}, w, 10, 1'b1, 1'b0);
  endtask

  initial begin
    int r1, r0;
    logic [127:0] nk;

    rst = 1'b1; load = 1'b0; next = 1'b0; rewind = 1'b0; key = '0;
    for (int i = 0; i < 256; i++) sb[i] = ref_sbox(8'(i));
    tick(); tick();
    chk_zero("reset");
    rst = 1'b0;

    // Known-answer expansion.
    load_and_expand("fips", FIPS_KEY);
    chk("fips_k10_const", rk1, FIPS_K10);

    // Reverse walk down to K0, then a further next holds.
    next = 1'b1;
    for (int j = 9; j >= 0; j--) begin
      tick();
      for (int w = 0; w < 2; w++) chk_dut("walk", w, j, 1'b1, 1'b0);
      if (j == 9) chk("fips_k9_const", rk1, FIPS_K9);
      if (j == 1) chk("fips_k1_const", rk1, FIPS_K1);
      if (j == 0) chk("fips_k0_const", rk1, FIPS_KEY);
    end
    tick();
    for (int w = 0; w < 2; w++) chk_dut("walk_hold0", w, 0, 1'b1, 1'b0);
    next = 1'b0;

    // Rewind: restores K10 with the copy, ignored without it.
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
    chk_dut("rewind", 1, 10, 1'b1, 1'b0);
    chk("rewind_const", rk1, FIPS_K10);
    chk_dut("rewind_ignored", 0, 0, 1'b1, 1'b0);

    // Random keys with random next/rewind traffic against the model.
    for (int n = 0; n < 4; n++) begin
      nk = {$urandom(), $urandom(), $urandom(), $urandom()};
      load_and_expand("rand", nk);
      r1 = 10; r0 = 10;
      for (int c = 0; c < 25; c++) begin
        next   = 1'($urandom_range(0, 1));
        rewind = ($urandom_range(0, 5) == 0);
        tick();
        if (rewind) r1 = 10;
        else if (next && r1 > 0) r1--;
        if (next && r0 > 0) r0--;
        chk_dut("rand_op", 1, r1, 1'b1, 1'b0);
        chk_dut("rand_op", 0, r0, 1'b1, 1'b0);
      end
      next = 1'b0; rewind = 1'b0;
    end

    // All-zero key with junk on load/next/rewind/key during expansion.
    build_rk('0);
    key = '0; load = 1'b1;
    tick();
    for (int j = 1; j <= 10; j++) begin
      load   = 1'($urandom_range(0, 1));
      next   = 1'($urandom_range(0, 1));
      rewind = 1'($urandom_range(0, 1));
      key    = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      if (j < 10) for (int w = 0; w < 2; w++) chk_dut("zero_exp", w, j, 1'b0, 1'b1);
    end
    load = 1'b0; next = 1'b0; rewind = 1'b0;
    for (int w = 0; w < 2; w++) chk_dut("zero_k10", w, 10, 1'b1, 1'b0);
    chk("zero_k10_const", rk1, ZERO_K10);

    // Walk to round 5, then load+rewind+next together: load wins.
    next = 1'b1;
    for (int j = 0; j < 5; j++) tick();
    next = 1'b0;
    chk_dut("prio_r5", 1, 5, 1'b1, 1'b0);
    nk = {$urandom(), $urandom(), $urandom(), $urandom()};
    key = nk; load = 1'b1; rewind = 1'b1; next = 1'b1;
    tick();
    load = 1'b0; rewind = 1'b0; next = 1'b0;
    build_rk(nk);
    for (int w = 0; w < 2; w++) chk_dut("prio_load", w, 0, 1'b0, 1'b1);
    for (int j = 1; j <= 10; j++) tick();
    for (int w = 0; w < 2; w++) chk_dut("prio_k10", w, 10, 1'b1, 1'b0);

    // Reset at expansion cycle 4.
    build_rk(FIPS_KEY);
    key = FIPS_KEY; load = 1'b1;
    tick();
    load = 1'b0;
    for (int j = 0; j < 4; j++) tick();
    chk_dut("pre_rst_exp", 1, 4, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("rst_exp");
    next = 1'b1; rewind = 1'b1;
    tick();
    next = 1'b0; rewind = 1'b0;
    chk_zero("idle_ignores");

    // Reset in READY at round 3.
    load_and_expand("pre_rst", FIPS_KEY);
    next = 1'b1;
    for (int j = 0; j < 7; j++) tick();
    next = 1'b0;
    chk_dut("pre_rst_r3", 1, 3, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("rst_ready");

    // Fresh load reproduces the known answer.
    load_and_expand("reload", FIPS_KEY);
    chk("reload_k10_const", rk1, FIPS_K10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
